// File: rtl/mem_arbiter.sv
// Two-requester line arbiter between the I-cache and D-cache miss engines and the single memory port.
// One transaction is in flight at a time; every output comes straight from a register.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t              state_q, state_d;
  logic                memRead_q, memRead_d;
  logic                memWrite_q, memWrite_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [DATA_W-1:0]   memWdata_q, memWdata_d;
  logic [DATA_W-1:0]   iRdata_q, iRdata_d;
  logic [DATA_W-1:0]   dRdata_q, dRdata_d;
  logic                iReady_q, iReady_d;
  logic                dReady_q, dReady_d;
  logic                grantD_q, grantD_d;
  logic                lastD_q, lastD_d;
  logic                timeoutErr_q, timeoutErr_d;
  logic [15:0]         wdCnt_q, wdCnt_d;

  logic iReq, dReq, pickD;

  assign iReq = i_read | i_write;
  assign dReq = d_read | d_write;
  // On a tie, round-robin hands the grant to the side that did not win last time.
  assign pickD = dReq & (~iReq | ~RR_EN | ~lastD_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      iRdata_q     <= '0;
      dRdata_q     <= '0;
      iReady_q     <= 1'b0;
      dReady_q     <= 1'b0;
      grantD_q     <= 1'b0;
      lastD_q      <= 1'b1;
      timeoutErr_q <= 1'b0;
      wdCnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      iRdata_q     <= iRdata_d;
      dRdata_q     <= dRdata_d;
      iReady_q     <= iReady_d;
      dReady_q     <= dReady_d;
      grantD_q     <= grantD_d;
      lastD_q      <= lastD_d;
      timeoutErr_q <= timeoutErr_d;
      wdCnt_q      <= wdCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    memRead_d    = memRead_q;
    memWrite_d   = memWrite_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    iRdata_d     = iRdata_q;
    dRdata_d     = dRdata_q;
    iReady_d     = 1'b0;
    dReady_d     = 1'b0;
    grantD_d     = grantD_q;
    lastD_d      = lastD_q;
    timeoutErr_d = timeoutErr_q;
    wdCnt_d      = wdCnt_q;

    case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          state_d  = BUSY;
          grantD_d = pickD;
          lastD_d  = pickD;
          wdCnt_d  = '0;
          // A requester asserting both read and write is treated as a write.
          if (pickD) begin
            memWrite_d = d_write;
            memRead_d  = ~d_write;
            memAddr_d  = d_addr;
            memWdata_d = d_wdata;
          end else begin
            memWrite_d = i_write;
            memRead_d  = ~i_write;
            memAddr_d  = i_addr;
            memWdata_d = i_wdata;
          end
        end
      end

      BUSY: begin
        if (mem_ready) begin
          memRead_d  = 1'b0;
          memWrite_d = 1'b0;
          state_d    = DONE;
          if (grantD_q) begin
            dReady_d = 1'b1;
            if (memRead_q) dRdata_d = mem_rdata;
          end else begin
            iReady_d = 1'b1;
            if (memRead_q) iRdata_d = mem_rdata;
          end
        end else if (TIMEOUT != 0) begin
          // The watchdog only flags a stall; the transaction keeps waiting.
          if (wdCnt_q != 16'hFFFF) wdCnt_d = wdCnt_q + 16'd1;
          if (wdCnt_q + 16'd1 == TIMEOUT_CNT) timeoutErr_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign i_rdata     = iRdata_q;
  assign i_ready     = iReady_q;
  assign d_rdata     = dRdata_q;
  assign d_ready     = dReady_q;
  assign mem_read    = memRead_q;
  assign mem_write   = memWrite_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign grant_d     = grantD_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 is round-robin with an 8-cycle watchdog,
// instance 1 is fixed D-priority with the watchdog disabled.
module tb_mem_arbiter;

  localparam logic [127:0] CAFE_LINE = 128'h0123_4567_89AB_CDEF_0000_1111_2222_CAFE;
  localparam logic [127:0] WB_LINE   = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
  localparam logic [27:0]  TIE_I_ADDR = 28'h0000100;
  localparam logic [27:0]  TIE_D_ADDR = 28'h0000200;

  logic         clk;
  logic         rst_n;
  logic         iRead[2], iWrite[2], dRead[2], dWrite[2];
  logic [27:0]  iAddr[2], dAddr[2];
  logic [127:0] iWdata[2], dWdata[2];
  logic [127:0] iRdata[2], dRdata[2];
  logic         iReady[2], dReady[2];
  logic         memRead[2], memWrite[2];
  logic [27:0]  memAddr[2];
  logic [127:0] memWdata[2], memRdata[2];
  logic         memReady[2];
  logic         grantD[2], timeoutErr[2];

  int vecCount = 0;
  int errCount = 0;

  for (genvar g = 0; g < 2; g++) begin : gDut
    mem_arbiter #(
      .ADDR_W (28),
      .DATA_W (128),
      .RR_EN  (g == 0),
      .TIMEOUT(g == 0 ? 8 : 0)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_read     (iRead[g]),
      .i_write    (iWrite[g]),
      .i_addr     (iAddr[g]),
      .i_wdata    (iWdata[g]),
      .i_rdata    (iRdata[g]),
      .i_ready    (iReady[g]),
      .d_read     (dRead[g]),
      .d_write    (dWrite[g]),
      .d_addr     (dAddr[g]),
      .d_wdata    (dWdata[g]),
      .d_rdata    (dRdata[g]),
      .d_ready    (dReady[g]),
      .mem_read   (memRead[g]),
      .mem_write  (memWrite[g]),
      .mem_addr   (memAddr[g]),
      .mem_wdata  (memWdata[g]),
      .mem_rdata  (memRdata[g]),
      .mem_ready  (memReady[g]),
      .grant_d    (grantD[g]),
      .timeout_err(timeoutErr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int k,
                               input logic ir, input logic iw, input logic [27:0] ia, input logic [127:0] iwd,
                               input logic dr, input logic dw, input logic [27:0] da, input logic [127:0] dwd);
    iRead[k]  = ir;
    iWrite[k] = iw;
    iAddr[k]  = ia;
    iWdata[k] = iwd;
    dRead[k]  = dr;
    dWrite[k] = dw;
    dAddr[k]  = da;
    dWdata[k] = dwd;
  endtask

  task automatic applyMem(input int k, input logic rdy, input logic [127:0] rd);
    memReady[k] = rdy;
    memRdata[k] = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One tie round from IDLE: expect the given winner, complete it, then optionally re-raise its read.
  task automatic runTie(input int k, input logic expD, input logic [127:0] rd, input logic reraise);
    step(1);
    checkOutput("tie strobe", memRead[k], 1'b1);
    checkOutput("tie grant_d", grantD[k], expD);
    checkOutput("tie addr", memAddr[k], expD ? TIE_D_ADDR : TIE_I_ADDR);
    applyMem(k, 1'b1, rd);
    step(1);
    checkOutput("tie winner ready", expD ? dReady[k] : iReady[k], 1'b1);
    checkOutput("tie loser ready", expD ? iReady[k] : dReady[k], 1'b0);
    checkOutput("tie rdata", expD ? dRdata[k] : iRdata[k], rd);
    applyMem(k, 1'b0, '0);
    if (expD) dRead[k] = 1'b0; else iRead[k] = 1'b0;
    step(1);
    if (reraise) begin
      if (expD) dRead[k] = 1'b1; else iRead[k] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim watchdog: simulation did not finish, expected it to");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      applyMem(k, 1'b0, '0);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset mem_read", memRead[k], 1'b0);
      checkOutput("reset mem_write", memWrite[k], 1'b0);
      checkOutput("reset grant_d", grantD[k], 1'b0);
      checkOutput("reset ready", {iReady[k], dReady[k]}, 2'b00);
      checkOutput("reset timeout_err", timeoutErr[k], 1'b0);
    end
    step(2);
    rst_n = 1'b1;

    // Single I-cache read, memory answers on the 4th strobe cycle.
    applyStimulus(0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0, 1'b0, '0, '0);
    step(1);
    checkOutput("ird strobe", memRead[0], 1'b1);
    checkOutput("ird no write", memWrite[0], 1'b0);
    checkOutput("ird addr", memAddr[0], 28'h0000010);
    checkOutput("ird grant_d", grantD[0], 1'b0);
    step(3);
    checkOutput("ird strobe held", memRead[0], 1'b1);
    checkOutput("ird addr held", memAddr[0], 28'h0000010);
    checkOutput("ird early ready", iReady[0], 1'b0);
    applyMem(0, 1'b1, CAFE_LINE);
    step(1);
    checkOutput("ird ready", iReady[0], 1'b1);
    checkOutput("ird rdata", iRdata[0], CAFE_LINE);
    checkOutput("ird d_ready", dReady[0], 1'b0);
    checkOutput("ird strobe drop", memRead[0], 1'b0);
    applyMem(0, 1'b0, '0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1);
    checkOutput("ird ready one cycle", iReady[0], 1'b0);
    checkOutput("ird no timeout", timeoutErr[0], 1'b0);

    // D-cache write-back, memory answers on the 2nd strobe cycle.
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 28'h00000A0, WB_LINE);
    step(1);
    checkOutput("dwb write", memWrite[0], 1'b1);
    checkOutput("dwb no read", memRead[0], 1'b0);
    checkOutput("dwb addr", memAddr[0], 28'h00000A0);
    checkOutput("dwb wdata", memWdata[0], WB_LINE);
    checkOutput("dwb grant_d", grantD[0], 1'b1);
    step(1);
    checkOutput("dwb wdata held", memWdata[0], WB_LINE);
    applyMem(0, 1'b1, 128'hDEAD);
    step(1);
    checkOutput("dwb ready", dReady[0], 1'b1);
    checkOutput("dwb i_ready", iReady[0], 1'b0);
    checkOutput("dwb d_rdata kept", dRdata[0], 128'h0);
    checkOutput("dwb i_rdata kept", iRdata[0], CAFE_LINE);
    checkOutput("dwb write drop", memWrite[0], 1'b0);
    applyMem(0, 1'b0, '0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1);

    // Ties straight out of reset on both instances.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, TIE_I_ADDR, '0, 1'b1, 1'b0, TIE_D_ADDR, '0);
    runTie(0, 1'b0, 128'hA1, 1'b1);
    runTie(0, 1'b1, 128'hB2, 1'b1);
    runTie(0, 1'b0, 128'hC3, 1'b1);
    runTie(0, 1'b1, 128'hD4, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

    applyStimulus(1, 1'b1, 1'b0, TIE_I_ADDR, '0, 1'b1, 1'b0, TIE_D_ADDR, '0);
    runTie(1, 1'b1, 128'h11, 1'b1);
    runTie(1, 1'b1, 128'h22, 1'b0);
    runTie(1, 1'b0, 128'h33, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1);

    // Reset while a read is in flight, then a clean re-grant.
    applyStimulus(0, 1'b1, 1'b0, 28'h0000055, '0, 1'b0, 1'b0, '0, '0);
    step(1);
    checkOutput("rst pre strobe", memRead[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mem_read", memRead[0], 1'b0);
    checkOutput("rst mem_addr", memAddr[0], 28'h0);
    checkOutput("rst i_ready", iReady[0], 1'b0);
    checkOutput("rst i_rdata", iRdata[0], 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst idle ready", iReady[0], 1'b0);
    step(1);
    checkOutput("rst regrant strobe", memRead[0], 1'b1);
    checkOutput("rst regrant addr", memAddr[0], 28'h0000055);
    checkOutput("rst regrant no ready", iReady[0], 1'b0);
    applyMem(0, 1'b1, 128'h5555);
    step(1);
    checkOutput("rst regrant ready", iReady[0], 1'b1);
    checkOutput("rst regrant rdata", iRdata[0], 128'h5555);
    applyMem(0, 1'b0, '0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1);

    // Watchdog: eight stalled BUSY cycles set the sticky flag.
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 28'h0000077, '0);
    step(1);
    checkOutput("wd first cycle", timeoutErr[0], 1'b0);
    step(7);
    checkOutput("wd cycle 8", timeoutErr[0], 1'b0);
    step(1);
    checkOutput("wd rises", timeoutErr[0], 1'b1);
    step(3);
    checkOutput("wd sticky", timeoutErr[0], 1'b1);
    checkOutput("wd still waiting", memRead[0], 1'b1);
    applyMem(0, 1'b1, 128'h7777);
    step(1);
    checkOutput("wd late ready", dReady[0], 1'b1);
    checkOutput("wd late rdata", dRdata[0], 128'h7777);
    checkOutput("wd err kept", timeoutErr[0], 1'b1);
    applyMem(0, 1'b0, '0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1);
    checkOutput("wd err after done", timeoutErr[0], 1'b1);
    checkOutput("wd disabled inst", timeoutErr[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
